boot_copier: RTL and testbench
==============================

Name: boot_copier

Overview:
- Post-reset copy engine that reads the 32-word boot ROM word by word and writes each word into main RAM at a programmable base address.
- Holds the CPU in reset-hold (cpu_hold=1) until the copy completes, then releases it.
- Sits between the boot ROM read port (drives cs/we/addr, consumes dout) and the RAM write port.
- Produces a 16-bit additive checksum of the copied image for firmware/debug readback.

Parameters:
- WORDS, 32, number of ROM words to copy (1..2^ROM_AW).
- ROM_AW, 5, ROM address width.
- RAM_AW, 12, RAM address width.
- DEST_BASE, 0, RAM word address of the first copied word.

Ports:
- romclk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  level; copy starts on the first cycle en=1 while in IDLE
- rom_cs  out  1  ROM chip select
- rom_we  out  1  ROM write enable; constant 0
- rom_addr  out  ROM_AW  ROM word address
- rom_dout  in  16  ROM read data, valid while rom_cs=1 and rom_we=0
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write strobe
- ram_addr  out  RAM_AW  RAM word address
- ram_din  out  16  RAM write data
- ram_ack  in  1  RAM accepted the write this cycle
- cpu_hold  out  1  1 = CPU held; 0 = CPU may fetch
- done  out  1  sticky copy-complete flag
- checksum  out  16  running sum of copied words, mod 2^16

Behaviour:
- Reset is async on rst rising and applies immediately. Values forced by reset:
  - state = IDLE, idx = 0, buf = 0, checksum = 0
  - rom_cs = 0, rom_we = 0, rom_addr = 0
  - ram_cs = 0, ram_we = 0, ram_addr = 0, ram_din = 0
  - cpu_hold = 1, done = 0
- All outputs are registered or decoded from registered state only; nothing is combinational from inputs.
- IDLE: all strobes 0. If en=1, go to ADDR. Otherwise stay.
- ADDR: rom_cs=1, rom_addr=idx. Next state is CAPT.
- CAPT:
  - rom_cs=1, rom_addr=idx held.
  - At the clock edge, buf <= rom_dout and checksum <= checksum + rom_dout (16-bit wrap, carry discarded).
  - Next state is WRITE.
- WRITE:
  - ram_cs=1, ram_we=1, ram_addr=DEST_BASE+idx (truncated to RAM_AW), ram_din=buf. rom_cs=0.
  - Stay in WRITE while ram_ack=0; address and data are held stable with no timeout.
  - On ram_ack=1: if idx==WORDS-1, go to DONE; else idx <= idx+1 and go to ADDR.
- DONE:
  - cpu_hold=0, done=1, all strobes 0. checksum is frozen.
  - Absorbing state; only rst exits it. en is ignored.
- Latency:
  - 3 cycles per word when ram_ack=1 during WRITE.
  - Full copy with ram_ack tied high: en sampled at edge 0, done=1 visible after edge 1+3*WORDS (97 for WORDS=32).
- Boundary conditions:
  - en deasserted mid-copy is ignored; the copy completes.
  - rst mid-copy aborts immediately, reinitialises all state, and the copy restarts from word 0 on the next en.
  - WORDS=1: a single ADDR/CAPT/WRITE pass, then DONE.
  - idx never exceeds WORDS-1. ram_addr wrap past 2^RAM_AW is silent truncation.
  - rom_cs and ram_cs are never 1 in the same cycle.
  - rom_we is never 1.

Decomposition:
- Shared package boot_pkg holds:
  - state enum copy_state_t {IDLE, ADDR, CAPT, WRITE, DONE}
  - BOOT_WORDS=32 and BOOT_ROM_AW=5
  - the default DEST_BASE localparam
- Single module; no sub-module needed. The checksum adder stays inline.

Test Plan:
- Basic copy: ROM model word i = 16'h1000+i, WORDS=32, ram_ack=1, en=1 -> RAM[0..31] = 16'h1000..16'h101F; checksum=16'h01F0; done rises at cycle 97; cpu_hold falls the same cycle.
- Back-pressure: ram_ack low for 5 cycles on word 3 -> ram_addr=3 and ram_din=16'h1003 held stable all 5 cycles; total completion = 102 cycles; RAM contents unchanged from the basic case.
- Mid-copy reset: assert rst while idx=10 -> all outputs at reset values in the same cycle. Re-enable -> copy restarts at word 0; final checksum=16'h01F0.
- Checksum wrap: ROM all 16'hFFFF -> checksum=16'hFFE0 (32*0xFFFF mod 2^16); done=1.
- DEST_BASE=12'h100, WORDS=1, word0=16'hF200 -> exactly one write, RAM[0x100]=16'hF200, done after 4 cycles.
- Protocol assertions over all tests: rom_we==0 always; never (rom_cs && ram_cs); en toggling after start has no effect; done stays 1 until rst.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot copy engine: FSM encoding and default geometry.
package boot_pkg;

   localparam int BOOT_WORDS     = 32;
   localparam int BOOT_ROM_AW    = 5;
   localparam int BOOT_RAM_AW    = 12;
   localparam int BOOT_DEST_BASE = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      CAPT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } copy_state_t;

endpackage

// File: rtl/boot_copier.sv
// Post-reset boot copier: streams WORDS words from the boot ROM into main RAM
// starting at DEST_BASE, holds the CPU until the image is in place and keeps a
// 16-bit additive checksum of everything copied.
module boot_copier
   import boot_pkg::*;
#(
   parameter int WORDS     = BOOT_WORDS,
   parameter int ROM_AW    = BOOT_ROM_AW,
   parameter int RAM_AW    = BOOT_RAM_AW,
   parameter int DEST_BASE = BOOT_DEST_BASE
) (
   input  logic              romclk,
   input  logic              rst,
   input  logic              en,
   output logic              rom_cs,
   output logic              rom_we,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_dout,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_din,
   input  logic              ram_ack,
   output logic              cpu_hold,
   output logic              done,
   output logic [15:0]       checksum
);

   localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(WORDS - 1);
   localparam logic [RAM_AW-1:0] BASE_A   = RAM_AW'(DEST_BASE);

   copy_state_t       state_q, state_d;
   logic [ROM_AW-1:0] idx_q, idx_d;
   logic [15:0]       buf_q, buf_d;
   logic [15:0]       sum_q, sum_d;
   logic              done_q, done_d;

   // State register; rst aborts any copy in progress immediately.
   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: one ROM read (ADDR, CAPT) then one RAM write per word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = ADDR;
         ADDR:    state_d = CAPT;
         CAPT:    state_d = WRITE;
         WRITE:   if (ram_ack) state_d = (idx_q == LAST_IDX) ? DONE : ADDR;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture ROM word and accumulate checksum in CAPT,
   // advance the word index only once the RAM has accepted the write.
   always_comb begin
      idx_d  = idx_q;
      buf_d  = buf_q;
      sum_d  = sum_q;
      done_d = (state_q == DONE);
      if (state_q == CAPT) begin
         buf_d = rom_dout;
         sum_d = sum_q + rom_dout;
      end
      if ((state_q == WRITE) && ram_ack && (idx_q != LAST_IDX)) begin
         idx_d = idx_q + ROM_AW'(1);
      end
   end

   // Datapath registers. done is flopped from the DONE state so the CPU
   // release comes straight off a register, one cycle after the last write.
   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         buf_q  <= '0;
         sum_q  <= '0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         buf_q  <= buf_d;
         sum_q  <= sum_d;
         done_q <= done_d;
      end
   end

   // Output decode from registered state only; buses are zeroed when idle.
   always_comb begin
      rom_cs   = 1'b0;
      rom_we   = 1'b0;
      rom_addr = '0;
      ram_cs   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      case (state_q)
         ADDR, CAPT: begin
            rom_cs   = 1'b1;
            rom_addr = idx_q;
         end
         WRITE: begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = BASE_A + RAM_AW'(idx_q);
            ram_din  = buf_q;
         end
         default: ;
      endcase
      done     = done_q;
      cpu_hold = ~done_q;
      checksum = sum_q;
   end

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: ROM image model, randomised RAM back-pressure and a
// word-level reference (expected write sequence, running sum, completion time).
module tb_boot_copier;
   import boot_pkg::*;

   localparam int W  = 32;
   localparam int DB = 0;

   logic        romclk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        rom_cs, rom_we, ram_cs, ram_we, cpu_hold, done;
   logic [4:0]  rom_addr;
   logic [15:0] rom_dout, ram_din, checksum;
   logic [11:0] ram_addr;
   logic        ram_ack = 1'b1;

   logic        en1 = 1'b0;
   logic        rom_cs1, rom_we1, ram_cs1, ram_we1, cpu_hold1, done1;
   logic [4:0]  rom_addr1;
   logic [15:0] rom_dout1, ram_din1, checksum1;
   logic [11:0] ram_addr1;

   logic [15:0] rom_mem [0:W-1];
   logic [15:0] ram_mem [0:4095];

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          wr_idx = 0;
   int          stall_cnt = 0;
   logic [15:0] sum_before = '0;
   bit          active = 1'b0;

   always #5 romclk = ~romclk;
   always @(posedge romclk) cyc <= cyc + 1;

   assign rom_dout  = rom_cs  ? rom_mem[rom_addr] : 16'h0BAD;
   assign rom_dout1 = rom_cs1 ? 16'hF200 : 16'h0BAD;

   boot_copier dut (
      .romclk(romclk), .rst(rst), .en(en),
      .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_ack(ram_ack), .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
   );

   boot_copier #(.WORDS(1), .DEST_BASE(12'h100)) dut1 (
      .romclk(romclk), .rst(rst), .en(en1),
      .rom_cs(rom_cs1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
      .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
      .ram_ack(1'b1), .cpu_hold(cpu_hold1), .done(done1), .checksum(checksum1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference comparison on every falling edge: expected write order,
   // checksum as the sum of words already captured, completion time.
   always @(negedge romclk) begin
      logic [15:0] cur;
      bit          exp_done;
      chk("rom_we_zero", 32'(rom_we), 32'd0);
      chk("cs_exclusive", 32'(rom_cs && ram_cs), 32'd0);
      chk("rom_we1_zero", 32'(rom_we1), 32'd0);
      chk("cs_exclusive1", 32'(rom_cs1 && ram_cs1), 32'd0);
      if (active) begin
         exp_done = (wr_idx == W) && ((cyc - start_cyc) >= (1 + 3 * W + stall_cnt));
         chk("done", 32'(done), 32'(exp_done));
         chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
         chk("ram_cs_eq_we", 32'(ram_cs), 32'(ram_we));
         if (rom_cs) chk("rom_addr", 32'(rom_addr), 32'(wr_idx));
         if (ram_we) begin
            chk("write_in_range", 32'(wr_idx < W), 32'd1);
            if (wr_idx < W) begin
               cur = rom_mem[wr_idx];
               chk("ram_addr", 32'(ram_addr), 32'(12'(DB + wr_idx)));
               chk("ram_din", 32'(ram_din), 32'(cur));
               chk("checksum_wr", 32'(checksum), 32'(16'(sum_before + cur)));
               if (ram_ack) begin
                  ram_mem[ram_addr] = ram_din;
                  sum_before = 16'(sum_before + cur);
                  wr_idx++;
               end else begin
                  stall_cnt++;
               end
            end
         end else begin
            chk("checksum", 32'(checksum), 32'(sum_before));
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_rom_cs"}, 32'(rom_cs), 32'd0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_checksum"}, 32'(checksum), 32'd0);
   endtask

   task automatic do_reset();
      active = 1'b0;
      @(negedge romclk);
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) @(negedge romclk);
      rst = 1'b0;
   endtask

   // mode 0: ack always high; 1: five stall cycles on word 3; 2: random ack.
   // abort_at >= 0 fires rst while the ROM read of that word is under way.
   task automatic run_copy(input int mode, input bit toggle_en, input int abort_at,
                           output int edges);
      int given;
      bit got;
      given      = 0;
      got        = 1'b0;
      wr_idx     = 0;
      stall_cnt  = 0;
      sum_before = '0;
      edges      = -1;
      for (int a = 0; a < 4096; a++) ram_mem[a] = 16'h0000;
      @(negedge romclk);
      en      = 1'b1;
      ram_ack = 1'b1;
      @(posedge romclk);
      #1;
      start_cyc = cyc;
      active    = 1'b1;
      for (int i = 0; i < 700; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (abort_at >= 0 && wr_idx == abort_at && rom_cs) begin
            active = 1'b0;
            rst    = 1'b1;
            en     = 1'b0;
            #1;
            check_reset("abort");
            return;
         end
         case (mode)
            1: begin
               if (ram_we && wr_idx == 3 && given < 5) begin
                  ram_ack = 1'b0;
                  given++;
               end else begin
                  ram_ack = 1'b1;
               end
            end
            2: ram_ack = ($urandom_range(0, 3) != 0);
            default: ram_ack = 1'b1;
         endcase
         if (toggle_en) en = 1'($urandom_range(0, 1));
         @(posedge romclk);
         #1;
      end
      chk("done_timeout", 32'(got), 32'd1);
      edges = cyc - start_cyc;
      chk("done_edge", 32'(edges), 32'(1 + 3 * W + stall_cnt));
      // done must be sticky whatever en does afterwards
      for (int i = 0; i < 8; i++) begin
         en      = 1'($urandom_range(0, 1));
         ram_ack = 1'($urandom_range(0, 1));
         @(posedge romclk);
         #1;
      end
      en = 1'b0;
      chk("writes_total", 32'(wr_idx), 32'(W));
      for (int i = 0; i < W; i++) chk("ram_image", 32'(ram_mem[DB + i]), 32'(rom_mem[i]));
   endtask

   initial begin
      int e;
      int s1;
      int nw1;
      bit got1;

      // reset state
      repeat (2) @(negedge romclk);
      check_reset("in_reset");
      rst = 1'b0;
      repeat (3) @(negedge romclk);
      check_reset("idle");

      // basic copy
      for (int i = 0; i < W; i++) rom_mem[i] = 16'(16'h1000 + i);
      run_copy(0, 1'b0, -1, e);
      chk("basic_edges", 32'(e), 32'd97);
      chk("basic_checksum", 32'(checksum), 32'h01F0);
      chk("basic_ram5", 32'(ram_mem[5]), 32'h1005);
      chk("basic_ram31", 32'(ram_mem[31]), 32'h101F);

      // back-pressure on word 3
      do_reset();
      run_copy(1, 1'b0, -1, e);
      chk("bp_edges", 32'(e), 32'd102);
      chk("bp_stalls", 32'(stall_cnt), 32'd5);
      chk("bp_checksum", 32'(checksum), 32'h01F0);

      // reset in the middle of word 10, then a full copy from word 0
      do_reset();
      run_copy(0, 1'b0, 10, e);
      chk("abort_taken", 32'(rst), 32'd1);
      @(negedge romclk);
      check_reset("abort_held");
      rst = 1'b0;
      @(negedge romclk);
      run_copy(0, 1'b0, -1, e);
      chk("restart_edges", 32'(e), 32'd97);
      chk("restart_checksum", 32'(checksum), 32'h01F0);

      // checksum wrap with en toggling during the copy
      do_reset();
      for (int i = 0; i < W; i++) rom_mem[i] = 16'hFFFF;
      run_copy(0, 1'b1, -1, e);
      chk("wrap_checksum", 32'(checksum), 32'hFFE0);
      chk("wrap_done", 32'(done), 32'd1);

      // random images under random back-pressure
      for (int t = 0; t < 3; t++) begin
         do_reset();
         for (int i = 0; i < W; i++) rom_mem[i] = 16'($urandom);
         run_copy(2, 1'b1, -1, e);
      end

      // single-word instance at a non-zero base
      do_reset();
      nw1  = 0;
      got1 = 1'b0;
      @(negedge romclk);
      en1 = 1'b1;
      @(posedge romclk);
      #1;
      s1 = cyc;
      for (int i = 0; i < 30; i++) begin
         if (done1) begin
            got1 = 1'b1;
            break;
         end
         if (ram_we1) begin
            nw1++;
            chk("one_ram_addr", 32'(ram_addr1), 32'h100);
            chk("one_ram_din", 32'(ram_din1), 32'hF200);
         end
         @(posedge romclk);
         #1;
      end
      chk("one_done_timeout", 32'(got1), 32'd1);
      chk("one_done_edge", 32'(cyc - s1), 32'd4);
      chk("one_writes", 32'(nw1), 32'd1);
      chk("one_checksum", 32'(checksum1), 32'hF200);
      chk("one_cpu_hold", 32'(cpu_hold1), 32'd0);
      en1 = 1'b0;
      repeat (3) @(negedge romclk);
      chk("one_done_sticky", 32'(done1), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
